// File: rtl/lib_switch_onehot_fifo.sv
// ---------------------------------------------------------------------------
// lib_switch_onehot_fifo
//   NxM one-hot crossbar with a DEPTH-entry elastic FIFO on every output.
//   The allocator drives a one-hot select row per output. Rows with more than
//   one bit set are treated as "select nothing" and flagged in a sticky error.
//   Multicast (one input feeding several outputs) is lock-step: the input is
//   only ready when every FIFO it feeds has room, so a word lands in all of
//   them on the same edge or in none.
//
// Ports
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   ce             clock enable; low freezes state and blocks all transfers
//   i_sel          [0:M-1][0:N-1] select matrix, i_sel[m][n] = out m takes in n
//   i_data         [0:N-1][WIDTH-1:0] input words
//   i_valid        [0:N-1] input word valid
//   o_ready        [0:N-1] input may transfer this cycle
//   o_data         [0:M-1][WIDTH-1:0] FIFO head, zero when empty
//   o_valid        [0:M-1] FIFO non-empty
//   i_ready        [0:M-1] downstream accepts the head word
//   i_err_clr      clears all sticky select errors
//   o_sel_err      [0:M-1] sticky: select row m had more than one bit set
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// lib_switch_onehot_fifo_lane
//   One output FIFO. The caller never pushes when full nor pops when empty,
//   so no internal guarding is needed. Storage is not reset: the head is
//   masked to zero while empty, so stale contents are never visible.
//
// Ports
//   push, push_data   write one word at the tail
//   pop               advance the head
//   full              count == DEPTH (registered)
//   not_empty         count != 0 (registered)
//   head_data         word at the head, zero when empty
// ---------------------------------------------------------------------------
module lib_switch_onehot_fifo_lane #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             not_empty,
   output logic [WIDTH-1:0] head_data
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign full      = (cnt_q == FULL_CNT);
   assign not_empty = (cnt_q != '0);
   assign head_data = not_empty ? mem_q[rd_ptr_q] : '0;
endmodule

module lib_switch_onehot_fifo #(
   parameter int N     = 5,
   parameter int M     = 5,
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       ce,
   input  logic [0:M-1][0:N-1]        i_sel,
   input  logic [0:N-1][WIDTH-1:0]    i_data,
   input  logic [0:N-1]               i_valid,
   output logic [0:N-1]               o_ready,
   output logic [0:M-1][WIDTH-1:0]    o_data,
   output logic [0:M-1]               o_valid,
   input  logic [0:M-1]               i_ready,
   input  logic                       i_err_clr,
   output logic [0:M-1]               o_sel_err
);
   logic [0:M-1]            sel_legal;
   logic [0:M-1][0:N-1]     eff_sel;    // select rows with illegal rows zeroed
   logic [0:N-1]            routed;     // input feeds at least one output
   logic [0:N-1]            blocked;    // some output it feeds is full
   logic [0:N-1]            fire;
   logic [0:M-1]            full;
   logic [0:M-1]            push;
   logic [0:M-1]            pop;
   logic [0:M-1][WIDTH-1:0] push_data;
   logic [0:M-1]            sel_err_q, sel_err_d;

   // An illegal row simply drops out of the matrix: that output idles and
   // the inputs it named see no routing from it.
   always_comb begin
      sel_legal = '0;
      eff_sel   = '0;
      for (int m = 0; m < M; m++) begin
         sel_legal[m] = ($countones(i_sel[m]) <= 1);
         eff_sel[m]   = sel_legal[m] ? i_sel[m] : '0;
      end
   end

   // Ready looks only at the select matrix, ce and registered FIFO counts,
   // never at valid/ready, so there is no combinational path through the
   // handshake and a full FIFO refuses a push even while it is popping.
   always_comb begin
      routed  = '0;
      blocked = '0;
      for (int n = 0; n < N; n++) begin
         for (int m = 0; m < M; m++) begin
            routed[n]  = routed[n]  | eff_sel[m][n];
            blocked[n] = blocked[n] | (eff_sel[m][n] & full[m]);
         end
      end
      o_ready = {N{ce}} & routed & ~blocked;
      fire    = i_valid & o_ready;
   end

   // A legal row has at most one bit, so at most one input can drive each
   // FIFO's write port in a cycle.
   always_comb begin
      push      = '0;
      push_data = '0;
      for (int m = 0; m < M; m++) begin
         for (int n = 0; n < N; n++) begin
            if (eff_sel[m][n] && fire[n]) begin
               push[m]      = 1'b1;
               push_data[m] = i_data[n];
            end
         end
      end
      pop = {M{ce}} & o_valid & i_ready;
   end

   for (genvar m = 0; m < M; m++) begin : g_lane
      lib_switch_onehot_fifo_lane #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_lane (
         .clk       (clk),
         .reset_n   (reset_n),
         .push      (push[m]),
         .push_data (push_data[m]),
         .pop       (pop[m]),
         .full      (full[m]),
         .not_empty (o_valid[m]),
         .head_data (o_data[m])
      );
   end

   // Sticky select error: a fresh illegal select wins over a clear.
   always_comb begin
      sel_err_d = sel_err_q;
      if (ce) sel_err_d = ~sel_legal | (sel_err_q & ~{M{i_err_clr}});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sel_err_q <= '0;
      else          sel_err_q <= sel_err_d;
   end

   assign o_sel_err = sel_err_q;
endmodule

// File: tb/tb_lib_switch_onehot_fifo.sv
module tb_lib_switch_onehot_fifo;
   localparam int N     = 5;
   localparam int M     = 5;
   localparam int WIDTH = 32;
   localparam int DEPTH = 2;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic                    ce = 1'b0;
   logic [0:M-1][0:N-1]     i_sel = '0;
   logic [0:N-1][WIDTH-1:0] i_data = '0;
   logic [0:N-1]            i_valid = '0;
   logic [0:N-1]            o_ready;
   logic [0:M-1][WIDTH-1:0] o_data;
   logic [0:M-1]            o_valid;
   logic [0:M-1]            i_ready = '0;
   logic                    i_err_clr = 1'b0;
   logic [0:M-1]            o_sel_err;

   lib_switch_onehot_fifo #(.N(N), .M(M), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce        (ce),
      .i_sel     (i_sel),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .i_err_clr (i_err_clr),
      .o_sel_err (o_sel_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: one queue per output ----------------
   logic [WIDTH-1:0] mq [M][$];
   logic [0:M-1]     merr = '0;

   function automatic logic mdl_ready(int n);
      int  hits = 0;
      logic room = 1'b1;
      for (int m = 0; m < M; m++)
         if ($countones(i_sel[m]) == 1 && i_sel[m][n]) begin
            hits++;
            if (mq[m].size() >= DEPTH) room = 1'b0;
         end
      return ce && hits > 0 && room;
   endfunction

   // Compare process: outputs are settled mid-cycle; check them, then
   // advance the model by what the coming rising edge will do.
   logic [0:N-1]            exp_rdy;
   logic [0:M-1]            exp_vld;
   logic [WIDTH-1:0]        exp_dat;
   logic [0:N-1]            mfire;
   always @(negedge clk) begin
      if (!reset_n) begin
         for (int m = 0; m < M; m++) mq[m].delete();
         merr = '0;
      end
      for (int n = 0; n < N; n++) exp_rdy[n] = mdl_ready(n);
      for (int m = 0; m < M; m++) begin
         exp_vld[m] = (mq[m].size() != 0);
         exp_dat    = exp_vld[m] ? mq[m][0] : '0;
         chk($sformatf("data%0d", m), o_data[m], exp_dat);
      end
      chk("ready", o_ready, exp_rdy);
      chk("valid", o_valid, exp_vld);
      chk("selerr", o_sel_err, merr);
      if (reset_n && ce) begin
         for (int n = 0; n < N; n++) mfire[n] = i_valid[n] && exp_rdy[n];
         for (int m = 0; m < M; m++)
            if (mq[m].size() != 0 && i_ready[m]) void'(mq[m].pop_front());
         for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
               if ($countones(i_sel[m]) == 1 && i_sel[m][n] && mfire[n])
                  mq[m].push_back(i_data[n]);
         for (int m = 0; m < M; m++)
            merr[m] = ($countones(i_sel[m]) > 1) || (merr[m] && !i_err_clr);
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      i_sel = '0; i_valid = '0; i_ready = '0; i_err_clr = 1'b0; i_data = '0; ce = 1'b1;
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_err", o_sel_err, 0);
      chk("rst_data2", o_data[2], 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Unicast: output 2 takes input 3, 8 back-to-back words.
      idle(); i_sel[2][3] = 1'b1; i_ready[2] = 1'b1; i_valid[3] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         i_data[3] = 32'hA5A50003 + k;
         cyc();
         chk("uni_valid", o_valid[2], 1);
         chk("uni_data", o_data[2], 32'hA5A50003 + k);
      end
      i_valid[3] = 1'b0;
      cyc();
      chk("uni_drain", o_valid[2], 0);

      // Multicast 1 -> {0,4} with output 4 stalled.
      idle(); i_sel[0][1] = 1'b1; i_sel[4][1] = 1'b1; i_ready[0] = 1'b1;
      i_valid[1] = 1'b1; i_data[1] = 32'd1;
      #1 chk("mc_rdy_a", o_ready[1], 1);
      cyc(); chk("mc_rdy_b", o_ready[1], 1); chk("mc_d0_a", o_data[0], 1); chk("mc_d4_a", o_data[4], 1);
      i_data[1] = 32'd2;
      cyc(); chk("mc_rdy_c", o_ready[1], 0); chk("mc_d0_b", o_data[0], 2); chk("mc_d4_b", o_data[4], 1);
      i_data[1] = 32'd3;
      cyc(); chk("mc_v0", o_valid[0], 0); chk("mc_rdy_d", o_ready[1], 0); chk("mc_d4_c", o_data[4], 1);
      i_ready[4] = 1'b1;
      cyc(); chk("mc_d4_d", o_data[4], 2); chk("mc_rdy_e", o_ready[1], 1); chk("mc_v0_b", o_valid[0], 0);
      cyc(); chk("mc_d0_c", o_data[0], 3); chk("mc_d4_e", o_data[4], 3);
      i_valid[1] = 1'b0;
      cyc(); chk("mc_empty", {o_valid[0], o_valid[4]}, 0);

      // Full boundary on output 1: pop + offered push -> push refused.
      idle(); i_sel[1][0] = 1'b1; i_valid[0] = 1'b1; i_data[0] = 32'h10;
      cyc(); i_data[0] = 32'h11;
      cyc(); chk("full_rdy", o_ready[0], 0); chk("full_head", o_data[1], 32'h10);
      i_ready[1] = 1'b1; i_data[0] = 32'h12;
      cyc(); chk("full_head2", o_data[1], 32'h11); chk("full_rdy2", o_ready[0], 1);
      i_valid[0] = 1'b0;
      cyc(); chk("full_cnt", o_valid[1], 0);

      // Illegal select on output 3.
      idle(); i_sel[3][0] = 1'b1; i_sel[3][2] = 1'b1; i_valid[0] = 1'b1; i_valid[2] = 1'b1;
      i_ready[3] = 1'b1;
      #1 chk("ill_rdy", {o_ready[0], o_ready[2]}, 0); chk("ill_err0", o_sel_err[3], 0);
      cyc(); chk("ill_err1", o_sel_err[3], 1); chk("ill_novalid", o_valid[3], 0);
      i_sel[3] = '0; i_valid = '0;
      cyc(); chk("ill_sticky", o_sel_err[3], 1);
      i_err_clr = 1'b1;
      cyc(); chk("ill_clr", o_sel_err[3], 0);
      i_sel[3][0] = 1'b1; i_sel[3][2] = 1'b1;
      cyc(); chk("ill_setwins", o_sel_err[3], 1);
      i_err_clr = 1'b0; i_sel[3] = '0;
      cyc(); chk("ill_hold", o_sel_err[3], 1);
      i_err_clr = 1'b1;
      cyc(); chk("ill_clr2", o_sel_err, 0);

      // ce gating.
      idle(); i_sel[2][4] = 1'b1; i_valid[4] = 1'b1; i_data[4] = 32'h77;
      cyc();
      ce = 1'b0; i_data[4] = 32'h88; i_ready[2] = 1'b1; i_sel[0][0] = 1'b1; i_sel[0][1] = 1'b1;
      repeat (5) begin
         cyc();
         chk("ce_rdy", o_ready, 0); chk("ce_valid", o_valid[2], 1);
         chk("ce_data", o_data[2], 32'h77); chk("ce_err", o_sel_err[0], 0);
      end
      i_sel[0] = '0; ce = 1'b1;
      cyc(); chk("ce_resume", o_data[2], 32'h88);
      i_valid[4] = 1'b0;
      cyc(); chk("ce_drain", o_valid[2], 0);

      // Reset with buffered words and a pending error.
      idle(); i_sel[1][2] = 1'b1; i_sel[3][2] = 1'b1; i_valid[2] = 1'b1; i_data[2] = 32'hDEAD;
      i_sel[0][3] = 1'b1; i_sel[0][4] = 1'b1;
      cyc(); cyc();
      reset_n = 1'b0;
      #1;
      chk("rst2_valid", o_valid, 0);
      chk("rst2_err", o_sel_err, 0);
      chk("rst2_rdy", o_ready, 5'b00100);
      for (int m = 0; m < M; m++) chk($sformatf("rst2_data%0d", m), o_data[m], 0);
      cyc();
      reset_n = 1'b1; idle();
      cyc();

      // Randomised traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         for (int m = 0; m < M; m++) begin
            int r;
            r = $urandom_range(0, 15);
            i_sel[m] = '0;
            if (r >= 6 && r < 15) i_sel[m][$urandom_range(0, N-1)] = 1'b1;
            else if (r == 15) begin
               i_sel[m][0] = 1'b1;
               i_sel[m][$urandom_range(1, N-1)] = 1'b1;
            end
         end
         for (int n = 0; n < N; n++) i_data[n] = $urandom;
         i_valid   = N'($urandom) | N'($urandom);
         i_ready   = N'($urandom) | N'($urandom & 32'h1f);
         ce        = ($urandom_range(0, 9) != 0);
         i_err_clr = ($urandom_range(0, 9) == 0);
         reset_n   = ($urandom_range(0, 299) != 0);
         cyc();
      end
      reset_n = 1'b1; idle();
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
